// File: rtl/cde_jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register, BYPASS and
// IDCODE data registers, and the final tdo mux feeding external DR cells.
module cde_jtag_tap_ctrl #(
    parameter int unsigned        IR_BITS      = 4,
    parameter logic [IR_BITS-1:0] IDCODE_INST  = IR_BITS'(1),
    parameter logic [IR_BITS-1:0] BYPASS_INST  = '1,
    parameter logic [31:0]        IDCODE_VALUE = 32'h1000_0001
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tms,
    input  logic               tdi,
    input  logic               tdo_dr,
    output logic               capture_dr,
    output logic               shift_dr,
    output logic               update_dr,
    output logic               capture_ir,
    output logic               shift_ir,
    output logic               update_ir,
    output logic               test_logic_reset,
    output logic [IR_BITS-1:0] instruction,
    output logic               bypass_sel,
    output logic               idcode_sel,
    output logic               tdo,
    output logic               tdo_en
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } state_t;

    localparam logic [IR_BITS-1:0] IR_CAPTURE = IR_BITS'(2'b01);

    state_t             state_q;
    state_t             state_d;
    logic [IR_BITS-1:0] ir_sr;
    logic               bypass_bit;
    logic [31:0]        idcode_sr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:      state_d = tms ? TLR    : RTI;
            RTI:      state_d = tms ? SEL_DR : RTI;
            SEL_DR:   state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR:   state_d = tms ? EX1_DR : SH_DR;
            SH_DR:    state_d = tms ? EX1_DR : SH_DR;
            EX1_DR:   state_d = tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: state_d = tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   state_d = tms ? UPD_DR : SH_DR;
            UPD_DR:   state_d = tms ? SEL_DR : RTI;
            SEL_IR:   state_d = tms ? TLR    : CAP_IR;
            CAP_IR:   state_d = tms ? EX1_IR : SH_IR;
            SH_IR:    state_d = tms ? EX1_IR : SH_IR;
            EX1_IR:   state_d = tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: state_d = tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   state_d = tms ? UPD_IR : SH_IR;
            UPD_IR:   state_d = tms ? SEL_DR : RTI;
            default:  state_d = TLR;
        endcase
    end

    // Strobes are flopped from the next state so each is a clean register
    // output covering exactly the cycles spent in its state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            test_logic_reset <= 1'b1;
            capture_dr       <= 1'b0;
            shift_dr         <= 1'b0;
            update_dr        <= 1'b0;
            capture_ir       <= 1'b0;
            shift_ir         <= 1'b0;
            update_ir        <= 1'b0;
        end else begin
            test_logic_reset <= (state_d == TLR);
            capture_dr       <= (state_d == CAP_DR);
            shift_dr         <= (state_d == SH_DR);
            update_dr        <= (state_d == UPD_DR);
            capture_ir       <= (state_d == CAP_IR);
            shift_ir         <= (state_d == SH_IR);
            update_ir        <= (state_d == UPD_IR);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_sr <= IDCODE_INST;
        end else if (state_q == CAP_IR) begin
            ir_sr <= IR_CAPTURE;
        end else if (state_q == SH_IR) begin
            ir_sr <= {tdi, ir_sr[IR_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction <= IDCODE_INST;
        end else if (state_d == TLR) begin
            instruction <= IDCODE_INST;
        end else if (state_q == UPD_IR) begin
            instruction <= ir_sr;
        end
    end

    assign bypass_sel = (instruction == BYPASS_INST);
    assign idcode_sel = (instruction == IDCODE_INST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bypass_bit <= 1'b0;
        end else if (bypass_sel && state_q == CAP_DR) begin
            bypass_bit <= 1'b0;
        end else if (bypass_sel && state_q == SH_DR) begin
            bypass_bit <= tdi;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idcode_sr <= IDCODE_VALUE;
        end else if (idcode_sel && state_q == CAP_DR) begin
            idcode_sr <= IDCODE_VALUE;
        end else if (idcode_sel && state_q == SH_DR) begin
            idcode_sr <= {tdi, idcode_sr[31:1]};
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (shift_ir) begin
            tdo = ir_sr[0];
        end else if (shift_dr) begin
            if (bypass_sel) begin
                tdo = bypass_bit;
            end else if (idcode_sel) begin
                tdo = idcode_sr[0];
            end else begin
                tdo = tdo_dr;
            end
        end
    end

    assign tdo_en = shift_dr | shift_ir;

endmodule

// File: tb/tb_cde_jtag_tap_ctrl.sv
// Self-checking bench: table-driven TAP model compared every cycle, plus
// directed scans with literal expectations and a randomized tms/tdi phase.
module tb_cde_jtag_tap_ctrl;

    localparam int unsigned IR_BITS = 4;
    localparam logic [3:0]  IDC     = 4'h1;
    localparam logic [3:0]  BYP     = 4'hF;
    localparam logic [31:0] IDV     = 32'h1000_0001;

    // Standard 1149.1 state codes, used only as table indices here.
    localparam int unsigned S_EX2DR = 0,  S_EX1DR = 1,  S_SHDR = 2,  S_PAUSEDR = 3;
    localparam int unsigned S_SELIR = 4,  S_UPDDR = 5,  S_CAPDR = 6, S_SELDR = 7;
    localparam int unsigned S_EX2IR = 8,  S_EX1IR = 9,  S_SHIR = 10, S_PAUSEIR = 11;
    localparam int unsigned S_RTI = 12,   S_UPDIR = 13, S_CAPIR = 14, S_TLR = 15;

    logic clk, reset, tms, tdi, tdo_dr;
    logic capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;
    logic test_logic_reset, bypass_sel, idcode_sel, tdo, tdo_en;
    logic [IR_BITS-1:0] instruction;

    int checks = 0;
    int failures = 0;

    cde_jtag_tap_ctrl #(
        .IR_BITS(IR_BITS), .IDCODE_INST(IDC), .BYPASS_INST(BYP), .IDCODE_VALUE(IDV)
    ) dut (
        .clk(clk), .reset(reset), .tms(tms), .tdi(tdi), .tdo_dr(tdo_dr),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
        .test_logic_reset(test_logic_reset), .instruction(instruction),
        .bypass_sel(bypass_sel), .idcode_sel(idcode_sel), .tdo(tdo), .tdo_en(tdo_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned nxt0[16];
    int unsigned nxt1[16];
    int unsigned m_state;
    int unsigned m_ir;
    int unsigned m_inst;
    logic        m_byp;
    logic [31:0] m_id;

    task automatic lnk(input int unsigned s, input int unsigned a, input int unsigned b);
        nxt0[s] = a;
        nxt1[s] = b;
    endtask

    initial begin
        lnk(S_TLR, S_RTI, S_TLR);         lnk(S_RTI, S_RTI, S_SELDR);
        lnk(S_SELDR, S_CAPDR, S_SELIR);   lnk(S_SELIR, S_CAPIR, S_TLR);
        lnk(S_CAPDR, S_SHDR, S_EX1DR);    lnk(S_CAPIR, S_SHIR, S_EX1IR);
        lnk(S_SHDR, S_SHDR, S_EX1DR);     lnk(S_SHIR, S_SHIR, S_EX1IR);
        lnk(S_EX1DR, S_PAUSEDR, S_UPDDR); lnk(S_EX1IR, S_PAUSEIR, S_UPDIR);
        lnk(S_PAUSEDR, S_PAUSEDR, S_EX2DR); lnk(S_PAUSEIR, S_PAUSEIR, S_EX2IR);
        lnk(S_EX2DR, S_SHDR, S_UPDDR);    lnk(S_EX2IR, S_SHIR, S_UPDIR);
        lnk(S_UPDDR, S_RTI, S_SELDR);     lnk(S_UPDIR, S_RTI, S_SELDR);
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state <= S_TLR;
            m_ir    <= IDC;
            m_inst  <= IDC;
            m_byp   <= 1'b0;
            m_id    <= IDV;
        end else begin
            m_state <= tms ? nxt1[m_state] : nxt0[m_state];
            if (m_state == S_CAPIR) m_ir <= 1;
            if (m_state == S_SHIR)  m_ir <= (m_ir >> 1) | (32'(tdi) << (IR_BITS - 1));
            if (m_state == S_CAPDR && m_inst == BYP) m_byp <= 1'b0;
            if (m_state == S_SHDR && m_inst == BYP)  m_byp <= tdi;
            if (m_state == S_CAPDR && m_inst == IDC) m_id <= IDV;
            if (m_state == S_SHDR && m_inst == IDC)  m_id <= (m_id >> 1) | (32'(tdi) << 31);
            if ((tms ? nxt1[m_state] : nxt0[m_state]) == S_TLR) m_inst <= IDC;
            else if (m_state == S_UPDIR) m_inst <= m_ir;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic       e_tdo;
        logic [6:0] e_strb;
        e_strb = {m_state == S_TLR, m_state == S_CAPDR, m_state == S_SHDR, m_state == S_UPDDR,
                  m_state == S_CAPIR, m_state == S_SHIR, m_state == S_UPDIR};
        if (m_state == S_SHIR)                      e_tdo = m_ir[0];
        else if (m_state == S_SHDR && m_inst == BYP) e_tdo = m_byp;
        else if (m_state == S_SHDR && m_inst == IDC) e_tdo = m_id[0];
        else if (m_state == S_SHDR)                  e_tdo = tdo_dr;
        else                                         e_tdo = 1'b0;
        chk("strobes", {test_logic_reset, capture_dr, shift_dr, update_dr,
                        capture_ir, shift_ir, update_ir}, e_strb);
        chk("instruction", instruction, m_inst);
        chk("sel", {bypass_sel, idcode_sel}, {m_inst == BYP, m_inst == IDC});
        chk("tdo", tdo, e_tdo);
        chk("tdo_en", tdo_en, m_state == S_SHDR || m_state == S_SHIR);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge clk);
        #2;
    endtask

    // From RTI: shift op into IR (LSB first) and return to RTI.
    task automatic load_ir(input logic [3:0] op);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 4; i++) step(i == 3, op[i]);
        step(1, 0);
        step(0, 0);
    endtask

    initial begin
        logic [31:0] got;
        logic [3:0]  pat;
        reset = 1'b0; tms = 1'b1; tdi = 1'b0; tdo_dr = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        chk("rst_tlr", test_logic_reset, 1);
        chk("rst_inst", instruction, 4'h1);
        chk("rst_idsel", idcode_sel, 1);
        chk("rst_tdo_en", {tdo, tdo_en}, 2'b00);
        repeat (3) step(1, 0);
        chk("tlr_hold", {test_logic_reset, instruction, idcode_sel}, {1'b1, 4'h1, 1'b1});

        // IDCODE scan
        step(0, 0); step(1, 0); step(0, 0);
        chk("cap_dr_on", capture_dr, 1);
        step(0, 0);
        chk("cap_dr_off", {capture_dr, shift_dr, tdo_en}, 3'b011);
        got = '0;
        for (int i = 0; i < 32; i++) begin
            got[i] = tdo;
            step(i == 31, 0);
        end
        chk("idcode_scan", got, 32'h1000_0001);
        step(1, 0);
        chk("upd_dr_on", update_dr, 1);
        step(0, 0);
        chk("upd_dr_off", update_dr, 0);

        // IR load of all ones
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        got = '0;
        for (int i = 0; i < 4; i++) begin
            got[i] = tdo;
            step(i == 3, 1);
        end
        chk("ir_capture", got, 32'h1);
        step(1, 0);
        chk("upd_ir_hold", {update_ir, instruction}, {1'b1, 4'h1});
        step(0, 0);
        chk("ir_bypass", {instruction, bypass_sel, idcode_sel}, {4'hF, 1'b1, 1'b0});

        // Bypass scan: 1,0,1 appears one cycle late
        pat = 4'b0101;
        step(1, 0); step(0, 0); step(0, 0);
        got = '0;
        for (int i = 0; i < 4; i++) begin
            got[i] = tdo;
            step(i == 3, pat[i]);
        end
        chk("bypass_scan", got, 32'hA);
        step(1, 0); step(0, 0);

        // User opcode: tdo follows tdo_dr
        load_ir(4'h5);
        chk("ir_user", {instruction, bypass_sel, idcode_sel}, {4'h5, 1'b0, 1'b0});
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 6; i++) begin
            tdo_dr = i[0];
            #1;
            chk("tdo_follow", tdo, i[0]);
            step(0, 0);
        end
        step(1, 0); step(1, 0);
        chk("upd_dr_user", {update_dr, bypass_sel, idcode_sel}, 3'b100);
        step(0, 0);
        chk("upd_dr_single", update_dr, 0);

        // Five tms=1 from Shift-DR
        step(1, 0); step(0, 0); step(0, 0);
        repeat (4) step(1, 0);
        chk("tms5_not_yet", test_logic_reset, 0);
        step(1, 0);
        chk("tms5_tlr", {test_logic_reset, instruction}, {1'b1, 4'h1});

        // Reset mid Shift-IR
        step(0, 0);
        load_ir(4'h5);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        step(0, 1); step(0, 1);
        reset = 1'b0;
        #1;
        chk("abort_state", {test_logic_reset, shift_ir, update_ir}, 3'b100);
        chk("abort_inst", instruction, 4'h1);
        chk("abort_tdo", {tdo, tdo_en}, 2'b00);
        step(1, 0); step(0, 0);
        chk("abort_held", test_logic_reset, 1);
        reset = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            tdo_dr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b0;
                #1;
                reset = 1'b1;
            end
            step($urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cde_jtag_tap_ctrl.md
Name: cde_jtag_tap_ctrl

Overview:
- IEEE 1149.1 TAP controller that sits directly upstream of the team's JTAG data-register cells (shift/capture/update registers).
- Runs the 16-state TAP FSM from tms and owns the instruction register.
- Supplies each downstream data register with its strobes: capture_dr, shift_dr, update_dr. Supplies select decode through the instruction output.
- Contains the mandatory BYPASS and IDCODE registers and muxes the final tdo.

Parameters:
- IR_BITS, 4, instruction register width (>=2).
- IDCODE_INST, 'h1, opcode selecting the IDCODE register; also the IR value after reset.
- BYPASS_INST, all ones ('hF at IR_BITS=4), opcode selecting the bypass bit.
- IDCODE_VALUE, 32'h1000_0001, 32-bit device ID; bit0 must be 1.

Ports:
- clk  input  1  TCK.
- reset  input  1  asynchronous, active-low; low forces Test-Logic-Reset.
- tms  input  1  test mode select, sampled on posedge clk.
- tdi  input  1  serial data in.
- tdo_dr  input  1  serial out of the externally selected user data register.
- capture_dr  output  1  high while in Capture-DR.
- shift_dr  output  1  high while in Shift-DR.
- update_dr  output  1  high while in Update-DR (one cycle per pass).
- capture_ir  output  1  high while in Capture-IR.
- shift_ir  output  1  high while in Shift-IR.
- update_ir  output  1  high while in Update-IR.
- test_logic_reset  output  1  high while in Test-Logic-Reset.
- instruction  output  IR_BITS  active instruction (shadow).
- bypass_sel  output  1  instruction == BYPASS_INST.
- idcode_sel  output  1  instruction == IDCODE_INST.
- tdo  output  1  serial data out.
- tdo_en  output  1  high in Shift-DR or Shift-IR.

Behaviour:
- FSM has 16 states, standard 1149.1 transitions on posedge clk, driven by tms:
  - TLR: tms=1 stays; tms=0 goes to RTI.
  - RTI: tms=0 stays; tms=1 goes to SelDR.
  - SelDR: tms=1 goes to SelIR; tms=0 goes to CapDR.
  - CapDR: tms=0 goes to ShDR; tms=1 goes to Ex1DR.
  - ShDR: tms=0 stays; tms=1 goes to Ex1DR.
  - Ex1DR: tms=0 goes to PauseDR; tms=1 goes to UpdDR.
  - PauseDR: tms=0 stays; tms=1 goes to Ex2DR.
  - Ex2DR: tms=0 goes to ShDR; tms=1 goes to UpdDR.
  - UpdDR: tms=0 goes to RTI; tms=1 goes to SelDR.
  - SelIR: tms=1 goes to TLR; tms=0 goes to CapIR.
  - IR branch (CapIR through UpdIR) mirrors the DR branch.
- From any state, 5 consecutive tms=1 cycles reach TLR.
- All strobe outputs are registered decodes of the next state. They are glitch-free and valid for exactly the cycles the FSM occupies the state. update_dr can therefore be used as a clock edge by downstream cells.
- Reset (reset=0, asynchronous):
  - state=TLR, test_logic_reset=1, all other strobes 0.
  - instruction=IDCODE_INST, idcode_sel=1, bypass_sel=0.
  - IR shift register=IDCODE_INST, bypass bit=0, idcode shift register=IDCODE_VALUE.
  - tdo=0, tdo_en=0.
- Entering TLR by tms also loads instruction=IDCODE_INST on the edge that enters TLR.
- IR shift register (IR_BITS):
  - CapIR loads {0..0,2'b01}.
  - ShIR shifts right, tdi into the MSB; tdo = LSB.
  - Other states hold.
- instruction updates from the IR shift register on the clk edge leaving UpdIR. It is stable otherwise, including across ShDR.
- Bypass bit:
  - CapDR with bypass_sel loads 0.
  - ShDR with bypass_sel loads tdi.
- IDCODE register (32 bits):
  - CapDR with idcode_sel loads IDCODE_VALUE.
  - ShDR with idcode_sel shifts right, tdi into bit31.
- Any opcode other than the two decoded ones: both sel=0, and the DR path uses tdo_dr. Downstream cells decode instruction for their select.
- tdo mux (combinational from registers):
  - ShIR: IR LSB.
  - ShDR: bypass bit if bypass_sel; else idcode LSB if idcode_sel; else tdo_dr.
  - Otherwise 0.
- Reset asserted mid-shift aborts immediately. No update strobe fires.
- Pause states hold all shift registers.

Test Plan:
- Reset release, tms=1 for 3 cycles -> state stays TLR; test_logic_reset=1; instruction=4'h1; idcode_sel=1.
- tms 0,1,0,0 then 32 ShDR cycles with tdi=0 -> tdo streams IDCODE_VALUE LSB first (1,0,0,0,...); capture_dr high exactly 1 cycle.
- Load IR 4'hF: tms 0,1,1,0,0, shift 4 tdi=1, then 1,1 -> IR capture shifts out 1,0,0,0; after UpdIR instruction=4'hF, bypass_sel=1; next DR scan of pattern 1,0,1 appears on tdo delayed by 1 cycle.
- Load opcode 4'h5, DR scan with tdo_dr toggled -> tdo follows tdo_dr; update_dr single-cycle pulse in UpdDR; both sel=0.
- From ShDR, hold tms=1 for 5 cycles -> reach TLR via Ex1DR, UpdDR, SelDR, SelIR; instruction reverts to 4'h1.
- Assert reset during ShIR after 2 shifts -> immediate TLR; instruction=4'h1; update_ir never asserted.
